fetch_queue: RTL and testbench

Decoupled, parametrised instruction-fetch front end for the pipelined core, replacing the single PC register and combinational instruction-memory read. It holds the PC, issues sequential requests to a variable-latency instruction memory over a valid/ready handshake, and buffers returned instructions with their PC and PC+4 in a DEPTH-entry FIFO. The decode register drains that FIFO. Branch redirects flush the queue and discard stale in-flight responses.

---
 rtl/fetch_queue.sv | 127 ++++++++++++
 tb/tb_fetch_queue.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Decoupled instruction-fetch front end: issues sequential PC requests to a variable-latency
// instruction memory and buffers returned instructions with their PCs for the decode stage.
module fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       imem_req_valid,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_req_ready,
    input  logic                       imem_rsp_valid,
    input  logic [31:0]                imem_rsp_data,
    output logic                       dec_valid,
    output logic [31:0]                dec_inst,
    output logic [XLEN-1:0]            dec_pc,
    output logic [XLEN-1:0]            dec_pcinc,
    input  logic                       dec_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

    logic [31:0]     inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];

    logic [CW:0] credit;
    logic        accept;
    logic        rsp_fire;
    logic        push;
    logic        pop;

    always_comb begin
        credit = {1'b0, count_q} + {1'b0, inflight_q};
        // Every in-flight request owns a queue slot, so a response can never overflow.
        imem_req_valid = !rst && !redirect_valid && (credit < (CW + 1)'(DEPTH));
        accept         = imem_req_valid && imem_req_ready;
        rsp_fire       = imem_rsp_valid && (inflight_q != '0);
        push           = rsp_fire && (drop_q == '0) && !redirect_valid;
        pop            = dec_valid && dec_ready && !redirect_valid;
    end

    always_comb begin
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        count_d    = count_q;
        inflight_d = inflight_q + CW'(accept) - CW'(rsp_fire);
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (redirect_valid) begin
            pc_d     = redirect_pc;
            rsp_pc_d = redirect_pc;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            // All outstanding responses are stale, including any already marked for drop.
            drop_d   = inflight_q - CW'(rsp_fire);
        end else begin
            if (accept) begin
                pc_d = pc_q + XLEN'(4);
            end
            if (rsp_fire && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                rsp_pc_d = rsp_pc_q + XLEN'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage needs no reset: count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= imem_rsp_data;
            pc_mem[wr_ptr_q]   <= rsp_pc_q;
        end
    end

    always_comb begin
        imem_req_addr = pc_q;
        dec_valid     = (count_q != '0);
        dec_inst      = inst_mem[rd_ptr_q];
        dec_pc        = pc_mem[rd_ptr_q];
        dec_pcinc     = pc_mem[rd_ptr_q] + XLEN'(4);
        occupancy     = count_q;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: behavioural instruction memory with programmable latency
// and a scoreboard of expected decode PCs checked on every pop.
module tb_fetch_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic            clk;
    logic            rst;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            dec_valid;
    logic [31:0]     dec_inst;
    logic [XLEN-1:0] dec_pc;
    logic [XLEN-1:0] dec_pcinc;
    logic            dec_ready;
    logic [CW-1:0]   occupancy;

    fetch_queue #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .RESET_PC('0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .dec_valid     (dec_valid),
        .dec_inst      (dec_inst),
        .dec_pc        (dec_pc),
        .dec_pcinc     (dec_pcinc),
        .dec_ready     (dec_ready),
        .occupancy     (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    int          n_vec   = 0;
    int          n_err   = 0;
    int          cyc     = 0;
    int          lat     = 1;
    int          acc_cnt = 0;
    logic [31:0] exp_q[$];
    req_t        mem_q[$];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory: in-order responses, each at least lat cycles after acceptance.
    always @(posedge clk) begin
        req_t r;
        #1;
        if (rst) begin
            mem_q.delete();
            imem_rsp_valid = 1'b0;
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            r              = mem_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(r.addr);
        end else begin
            imem_rsp_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        req_t r;
        if (rst) begin
            mem_q.delete();
        end else begin
            check("credit_le_depth",
                  32'((int'(occupancy) + mem_q.size() + int'(imem_rsp_valid)) <= DEPTH), 32'd1);
            if (imem_req_valid && imem_req_ready) begin
                r.addr = imem_req_addr;
                r.due  = cyc + lat;
                mem_q.push_back(r);
                acc_cnt++;
            end
        end
    end

    // Scoreboard monitor: every pop must match the oldest expected PC.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst && dec_valid && dec_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pop: got pc 0x%08h, want no entry", dec_pc);
            end else begin
                e = exp_q.pop_front();
                check("dec_pc", dec_pc, e);
                check("dec_pcinc", dec_pcinc, e + 32'd4);
                check("dec_inst", dec_inst, inst_of(e));
            end
        end
    end

    // Leaves the bench at the start of the first cycle after reset release.
    task automatic do_reset(input logic rdy, input logic dr);
        step();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_dec_valid", 32'(dec_valid), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        step();
        imem_req_ready = rdy;
        dec_ready      = dr;
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input string name, input int leftover);
        int t;
        t = 0;
        step();
        imem_req_ready = 1'b0;
        dec_ready      = 1'b1;
        forever begin
            @(negedge clk);
            if ((!dec_valid && mem_q.size() == 0 && !imem_rsp_valid) || t >= 60) break;
            t++;
        end
        check({name, "_drained"}, 32'(t < 60), 32'd1);
        check({name, "_leftover"}, 32'(exp_q.size()), 32'(leftover));
    endtask

    initial begin
        int left;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        dec_ready      = 1'b1;

        // Stream at L=1: first request in cycle 1, first decode in cycle 3, then one per cycle.
        lat = 1;
        do_reset(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
        @(negedge clk);
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0);
        step();
        @(negedge clk);
        check("no_bypass", 32'(dec_valid), 32'd0);
        step();
        @(negedge clk);
        check("stream_first_valid", 32'(dec_valid), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 5) imem_req_ready = 1'b0;
            @(negedge clk);
            check("stream_rate", 32'(dec_valid), 32'd1);
        end
        drain("stream", 0);

        // Back-pressure: decode stalled, queue fills to DEPTH and requests stop.
        do_reset(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) exp_q.push_back(32'(4 * i));
        repeat (9) step();
        @(negedge clk);
        check("bp_occupancy", 32'(occupancy), 32'd4);
        check("bp_req_valid", 32'(imem_req_valid), 32'd0);
        check("bp_head_valid", 32'(dec_valid), 32'd1);
        check("bp_head_pc", dec_pc, 32'h0);
        step();
        dec_ready      = 1'b1;
        imem_req_ready = 1'b0;
        step();
        imem_req_ready = 1'b1;
        @(negedge clk);
        check("bp_resume_req", 32'(imem_req_valid), 32'd1);
        check("bp_resume_addr", imem_req_addr, 32'h10);
        step();
        imem_req_ready = 1'b0;
        drain("backpressure", 0);

        // Redirect with three requests in flight at L=3.
        lat = 3;
        do_reset(1'b1, 1'b1);
        step();
        step();
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        exp_q.delete();
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        check("redir_flush_valid", 32'(dec_valid), 32'd0);
        check("redir_req_valid", 32'(imem_req_valid), 32'd1);
        check("redir_req_addr", imem_req_addr, 32'h100);
        step();
        step();
        imem_req_ready = 1'b0;
        step();
        @(negedge clk);
        check("redir_not_early", 32'(dec_valid), 32'd0);
        step();
        @(negedge clk);
        check("redir_target_valid", 32'(dec_valid), 32'd1);
        check("redir_target_pc", dec_pc, 32'h100);
        drain("redirect", 0);

        // Redirect coinciding with an arriving response and a would-be pop.
        lat = 1;
        do_reset(1'b1, 1'b1);
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h200 + 32'(4 * i));
        @(negedge clk);
        check("coincide_head", 32'(dec_valid), 32'd1);
        check("coincide_rsp", 32'(imem_rsp_valid), 32'd1);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("coincide_flush_valid", 32'(dec_valid), 32'd0);
        check("coincide_flush_occ", 32'(occupancy), 32'd0);
        check("coincide_req_addr", imem_req_addr, 32'h200);
        step();
        step();
        step();
        imem_req_ready = 1'b0;
        drain("coincide", 0);

        // Random handshakes and latency; every decoded PC must follow the sequence.
        do_reset(1'b1, 1'b1);
        for (int i = 0; i < 6000; i++) exp_q.push_back(32'(4 * i));
        acc_cnt = 0;
        for (int i = 0; i < 6000; i++) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            dec_ready      = 1'($urandom_range(0, 1));
            lat            = int'($urandom_range(1, 4));
            step();
        end
        imem_req_ready = 1'b0;
        lat            = 1;
        left           = 6000 - acc_cnt;
        drain("random", left);

        // Asynchronous reset between clock edges, then restart from the reset PC.
        do_reset(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) exp_q.push_back(32'(4 * i));
        repeat (5) step();
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_dec_valid", 32'(dec_valid), 32'd0);
        check("async_rst_occupancy", 32'(occupancy), 32'd0);
        check("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'(4 * i));
        @(negedge clk);
        check("restart_req_valid", 32'(imem_req_valid), 32'd1);
        check("restart_req_addr", imem_req_addr, 32'h0);
        step();
        step();
        step();
        imem_req_ready = 1'b0;
        drain("restart", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
